// File: rtl/pipe_arbiter.sv
// -----------------------------------------------------------------------------
// pipe_arbiter
//
// Shares the single 16-bit host pipe write port between up to 16 frame-producing
// requesters. It grants whole fixed-length frames with rotating priority, so
// frames from different sources never interleave on the host stream. All logic
// runs in the clk_in domain.
//
// Optional feature macro: PIPE_ARB_TAG_EN
//   Defined   : every frame is preceded by a tag word {8'h23, 4'h0, id[3:0]}
//               emitted from an extra HDR state.
//   Undefined : IDLE goes straight to XFER and no tag word is emitted.
//
// Parameters
//   N_REQ        number of requesters, 1..16
//   FRAME_WORDS  payload words per frame, 1..65535
//
// Ports
//   clk_in         system clock, rising edge
//   rst_in         synchronous active-high reset
//   PipeFull_in    pipe endpoint cannot accept a word this cycle
//   req_in         per-requester "complete frame ready" (sampled only in IDLE)
//   data_in        requester i's current word on bits [16i+15:16i]
//   grant_out      registered one-hot (or zero) owner of the pipe
//   ack_out        combinational one-hot: granted word consumed this cycle
//   PipeWrite_out  registered write strobe to the pipe
//   PipeData_out   registered write data to the pipe
//   busy_out       arbiter is not idle
// -----------------------------------------------------------------------------
module pipe_arbiter #(
    parameter int unsigned N_REQ       = 4,
    parameter int unsigned FRAME_WORDS = 16
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  PipeFull_in,
    input  logic [N_REQ-1:0]      req_in,
    input  logic [16*N_REQ-1:0]   data_in,
    output logic [N_REQ-1:0]      grant_out,
    output logic [N_REQ-1:0]      ack_out,
    output logic                  PipeWrite_out,
    output logic [15:0]           PipeData_out,
    output logic                  busy_out
);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StHdr  = 2'd1,
        StXfer = 2'd2
    } state_e;

    localparam logic [15:0] LastWord    = 16'(FRAME_WORDS - 1);
    localparam logic [3:0]  LastIdReset = 4'(N_REQ - 1);

    // Registered state
    state_e             r_state;
    logic [N_REQ-1:0]   r_grant;
    logic [3:0]         r_last_id;
    logic [15:0]        r_word_cnt;
    logic               r_pipe_write;
    logic [15:0]        r_pipe_data;

    // Next-state and helper nets
    state_e             w_state;
    logic [N_REQ-1:0]   w_grant;
    logic [3:0]         w_last_id;
    logic [15:0]        w_word_cnt;
    logic               w_pipe_write;
    logic [15:0]        w_pipe_data;
    logic [N_REQ-1:0]   w_ack;

    logic [3:0]         w_start;
    logic [N_REQ-1:0]   w_req_rot;
    logic               w_req_found;
    logic [3:0]         w_req_sel;
    logic [N_REQ-1:0]   w_sel_onehot;
    logic [3:0]         w_grant_id;
    logic [15:0]        w_word;

    // Index arithmetic modulo N_REQ; inputs never exceed 2*N_REQ-2.
    function automatic logic [3:0] wrap_id(input logic [4:0] v);
        if (v >= 5'(N_REQ)) begin
            wrap_id = 4'(v - 5'(N_REQ));
        end else begin
            wrap_id = v[3:0];
        end
    endfunction

    // Rotating-priority search. The request vector is rotated so that bit 0
    // is requester last_id+1; the first set bit of the rotated vector is the
    // winner, mapped back to an absolute index.
    always_comb begin
        w_start      = (r_last_id == LastIdReset) ? 4'd0 : (r_last_id + 4'd1);
        w_req_rot    = N_REQ'({req_in, req_in} >> w_start);
        w_req_found  = 1'b0;
        w_req_sel    = 4'd0;
        for (int i = 0; i < int'(N_REQ); i++) begin
            if (!w_req_found && w_req_rot[i]) begin
                w_req_found = 1'b1;
                w_req_sel   = wrap_id(5'(w_start) + 5'(i));
            end
        end
        w_sel_onehot = '0;
        for (int i = 0; i < int'(N_REQ); i++) begin
            w_sel_onehot[i] = (w_req_sel == 4'(i));
        end
    end

    // Encode the granted index and select the granted requester's word.
    always_comb begin
        w_grant_id = 4'd0;
        w_word     = 16'h0000;
        for (int i = 0; i < int'(N_REQ); i++) begin
            if (r_grant[i]) begin
                w_grant_id = 4'(i);
            end
            w_word = w_word | (data_in[16*i +: 16] & {16{r_grant[i]}});
        end
    end

    // Next-state and output logic
    always_comb begin
        w_state      = r_state;
        w_grant      = r_grant;
        w_last_id    = r_last_id;
        w_word_cnt   = r_word_cnt;
        w_pipe_write = 1'b0;
        w_pipe_data  = r_pipe_data;
        w_ack        = '0;

        case (r_state)
            StIdle: begin
                if (w_req_found) begin
                    w_grant    = w_sel_onehot;
                    w_word_cnt = 16'd0;
`ifdef PIPE_ARB_TAG_EN
                    w_state    = StHdr;
`else
                    w_state    = StXfer;
`endif
                end
            end

`ifdef PIPE_ARB_TAG_EN
            StHdr: begin
                // Tag word carries the source id; it is not a requester word,
                // so no ack is raised.
                if (!PipeFull_in) begin
                    w_pipe_write = 1'b1;
                    w_pipe_data  = {8'h23, 4'h0, w_grant_id};
                    w_state      = StXfer;
                end
            end
`endif

            StXfer: begin
                w_ack = r_grant & {N_REQ{~PipeFull_in}};
                if (!PipeFull_in) begin
                    w_pipe_write = 1'b1;
                    w_pipe_data  = w_word;
                    w_word_cnt   = r_word_cnt + 16'd1;
                    if (r_word_cnt == LastWord) begin
                        w_grant   = '0;
                        w_last_id = w_grant_id;
                        w_state   = StIdle;
                    end
                end
            end

            default: begin
                w_state = StIdle;
                w_grant = '0;
            end
        endcase
    end

    // State registers
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state      <= StIdle;
            r_grant      <= '0;
            r_last_id    <= LastIdReset;
            r_word_cnt   <= 16'd0;
            r_pipe_write <= 1'b0;
            r_pipe_data  <= 16'h0000;
        end else begin
            r_state      <= w_state;
            r_grant      <= w_grant;
            r_last_id    <= w_last_id;
            r_word_cnt   <= w_word_cnt;
            r_pipe_write <= w_pipe_write;
            r_pipe_data  <= w_pipe_data;
        end
    end

    assign grant_out     = r_grant;
    assign ack_out       = w_ack;
    assign PipeWrite_out = r_pipe_write;
    assign PipeData_out  = r_pipe_data;
    assign busy_out      = (r_state != StIdle);

endmodule

// File: tb/tb_pipe_arbiter.sv
// -----------------------------------------------------------------------------
// tb_pipe_arbiter
//
// Self-checking bench for pipe_arbiter (N_REQ=4, FRAME_WORDS=4). A transaction
// level model (owner index, words sent, last owner) predicts every output on
// every cycle; directed scenarios add literal expectations for word streams
// and grant order, followed by a randomized soak.
// -----------------------------------------------------------------------------
module tb_pipe_arbiter;

    localparam int unsigned N  = 4;
    localparam int unsigned FW = 4;
`ifdef PIPE_ARB_TAG_EN
    localparam int TAGW = 1;
`else
    localparam int TAGW = 0;
`endif

    logic              clk_in = 1'b0;
    logic              rst_in;
    logic              PipeFull_in;
    logic [N-1:0]      req_in;
    logic [16*N-1:0]   data_in;
    logic [N-1:0]      grant_out;
    logic [N-1:0]      ack_out;
    logic              PipeWrite_out;
    logic [15:0]       PipeData_out;
    logic              busy_out;

    always #5 clk_in = ~clk_in;

    pipe_arbiter #(
        .N_REQ       (N),
        .FRAME_WORDS (FW)
    ) dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .PipeFull_in   (PipeFull_in),
        .req_in        (req_in),
        .data_in       (data_in),
        .grant_out     (grant_out),
        .ack_out       (ack_out),
        .PipeWrite_out (PipeWrite_out),
        .PipeData_out  (PipeData_out),
        .busy_out      (busy_out)
    );

    int checks   = 0;
    int failures = 0;

    // Requester i, frame f, word k. Requester 2's first frame reads A000..A003.
    function automatic logic [15:0] word_of(input int i, input int f, input int k);
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] c;
        a = 4'(i ^ 2);
        b = 4'(f);
        c = 4'(k);
        return {4'hA, a, b, c};
    endfunction

    function automatic logic [N-1:0] onehot(input int k);
        if (k < 0) return '0;
        return N'(1) << k;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Requester environment: each advances its word on an ack.
    int rq_idx[N];
    int rq_frame[N];

    always_comb begin
        data_in = '0;
        for (int i = 0; i < int'(N); i++) begin
            data_in[16*i +: 16] = word_of(i, rq_frame[i], rq_idx[i]);
        end
    end

    // Behavioural model
    int          m_owner;
    int          m_sent;
    int          m_last;
    bit          m_hdr;
    bit          m_wr;
    logic [15:0] m_data;
    int          m_frame[N];
    bit          m_valid = 1'b0;

    int          n_owner;
    int          n_sent;
    int          n_last;
    bit          n_hdr;
    bit          n_wr;
    logic [15:0] n_data;
    bit          n_rst;
    int          n_fdone;

    logic [15:0] wr_log[$];
    int          glog[$];
    logic [N-1:0] prev_grant = '0;
    logic [N-1:0] ack_cap;

    task automatic model_next();
        n_owner = m_owner;
        n_sent  = m_sent;
        n_last  = m_last;
        n_hdr   = m_hdr;
        n_wr    = 1'b0;
        n_data  = m_data;
        n_rst   = 1'b0;
        n_fdone = -1;
        if (rst_in) begin
            n_owner = -1;
            n_sent  = 0;
            n_last  = N - 1;
            n_hdr   = 1'b0;
            n_data  = 16'h0000;
            n_rst   = 1'b1;
        end else if (m_owner < 0) begin
            for (int k = 1; k <= int'(N); k++) begin
                int j;
                j = (m_last + k) % N;
                if (n_owner < 0 && req_in[j]) begin
                    n_owner = j;
                    n_sent  = 0;
                    n_hdr   = (TAGW == 1);
                end
            end
        end else if (m_hdr) begin
            if (!PipeFull_in) begin
                n_wr   = 1'b1;
                n_data = 16'(16'h2300 | m_owner);
                n_hdr  = 1'b0;
            end
        end else if (!PipeFull_in) begin
            n_wr   = 1'b1;
            n_data = word_of(m_owner, m_frame[m_owner], m_sent);
            n_sent = m_sent + 1;
            if (n_sent == int'(FW)) begin
                n_last  = m_owner;
                n_owner = -1;
                n_fdone = m_owner;
            end
        end
    endtask

    task automatic tick();
        logic [N-1:0] exp_grant;
        logic [N-1:0] exp_ack;
        @(negedge clk_in);
        if (m_valid) begin
            exp_grant = onehot(m_owner);
            exp_ack   = (m_owner >= 0 && !m_hdr && !PipeFull_in) ? exp_grant : '0;
            chk("grant", grant_out, exp_grant);
            chk("ack", ack_out, exp_ack);
            chk("busy", busy_out, (m_owner >= 0));
            chk("write", PipeWrite_out, m_wr);
            chk("data", PipeData_out, m_data);
        end
        if (PipeWrite_out === 1'b1) wr_log.push_back(PipeData_out);
        if (grant_out != '0 && prev_grant == '0) begin
            int gi;
            gi = -1;
            for (int i = 0; i < int'(N); i++) if (grant_out[i]) gi = i;
            glog.push_back(gi);
        end
        prev_grant = grant_out;
        ack_cap    = ack_out;
        model_next();
        @(posedge clk_in);
        #1;
        m_owner = n_owner;
        m_sent  = n_sent;
        m_last  = n_last;
        m_hdr   = n_hdr;
        m_wr    = n_wr;
        m_data  = n_data;
        if (n_rst) begin
            for (int i = 0; i < int'(N); i++) m_frame[i] = 0;
            m_valid = 1'b1;
        end
        if (n_fdone >= 0) m_frame[n_fdone]++;
        for (int i = 0; i < int'(N); i++) begin
            if (rst_in) begin
                rq_idx[i]   = 0;
                rq_frame[i] = 0;
            end else if (ack_cap[i] === 1'b1) begin
                rq_idx[i]++;
                if (rq_idx[i] == int'(FW)) begin
                    rq_idx[i] = 0;
                    rq_frame[i]++;
                end
            end
        end
    endtask

    task automatic do_reset();
        rst_in      = 1'b1;
        req_in      = '0;
        PipeFull_in = 1'b0;
        tick();
        tick();
        rst_in = 1'b0;
        wr_log.delete();
        glog.delete();
    endtask

    task automatic wait_writes(input int n, input int budget, input string name);
        int c;
        c = 0;
        while (wr_log.size() < n && c < budget) begin
            tick();
            c++;
        end
        chk(name, (wr_log.size() >= n), 1);
    endtask

    task automatic wait_grants(input int n, input int budget, input string name);
        int c;
        c = 0;
        while (glog.size() < n && c < budget) begin
            tick();
            c++;
        end
        chk(name, (glog.size() >= n), 1);
    endtask

    task automatic wait_idle(input int budget, input string name);
        int c;
        c = 0;
        while (busy_out !== 1'b0 && c < budget) begin
            tick();
            c++;
        end
        chk(name, busy_out, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        logic [15:0] exp_words[$];
        int unsigned fl;
        fl = FW + TAGW;
        rst_in      = 1'b1;
        req_in      = '0;
        PipeFull_in = 1'b0;
        for (int i = 0; i < int'(N); i++) begin
            rq_idx[i]   = 0;
            rq_frame[i] = 0;
        end

        // Single requester frame
        do_reset();
        chk("rst_grant", grant_out, 0);
        chk("rst_write", PipeWrite_out, 0);
        chk("rst_data", PipeData_out, 16'h0000);
        chk("rst_busy", busy_out, 0);
        req_in = 4'b0100;
        tick();
        chk("t1_grant", grant_out, 4'b0100);
        req_in = '0;
        wait_writes(int'(fl), 20, "t1_timeout");
        chk("t1_busy_low", busy_out, 0);
`ifdef PIPE_ARB_TAG_EN
        exp_words = '{16'h2302, 16'hA000, 16'hA001, 16'hA002, 16'hA003};
`else
        exp_words = '{16'hA000, 16'hA001, 16'hA002, 16'hA003};
`endif
        chk("t1_len", wr_log.size(), exp_words.size());
        for (int i = 0; i < exp_words.size() && i < wr_log.size(); i++) begin
            chk("t1_word", wr_log[i], exp_words[i]);
        end

        // All requesting: rotation 0,1,2,3,0
        do_reset();
        req_in = 4'b1111;
        wait_grants(5, 200, "t2_timeout");
        req_in = '0;
        wait_writes(int'(5 * fl), 60, "t2_wr_timeout");
        for (int i = 0; i < 5 && i < glog.size(); i++) begin
            chk("t2_order", glog[i], i % 4);
        end
        if (wr_log.size() >= int'(5 * fl)) begin
            chk("t2_req3_first", wr_log[3*fl], (TAGW == 1) ? 16'h2303 : 16'hA100);
            chk("t2_req0_frame1", wr_log[4*fl + TAGW], 16'hA210);
        end

        // Back-pressure mid-frame
        do_reset();
        req_in = 4'b0001;
        wait_grants(1, 10, "t3_grant_timeout");
        req_in = '0;
        wait_writes(TAGW + 2, 20, "t3_timeout");
        PipeFull_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t3_full_ack", ack_out, 0);
        end
        PipeFull_in = 1'b0;
        wait_writes(int'(fl), 20, "t3_wr_timeout");
        wait_idle(10, "t3_idle");
        tick();
        tick();
`ifdef PIPE_ARB_TAG_EN
        exp_words = '{16'h2300, 16'hA200, 16'hA201, 16'hA202, 16'hA203};
`else
        exp_words = '{16'hA200, 16'hA201, 16'hA202, 16'hA203};
`endif
        chk("t3_len", wr_log.size(), exp_words.size());
        for (int i = 0; i < exp_words.size() && i < wr_log.size(); i++) begin
            chk("t3_word", wr_log[i], exp_words[i]);
        end

        // Reset mid-frame
        do_reset();
        req_in = 4'b1111;
        wait_writes(TAGW + 2, 20, "t4_timeout");
        rst_in = 1'b1;
        tick();
        chk("t4_rst_grant", grant_out, 0);
        chk("t4_rst_write", PipeWrite_out, 0);
        chk("t4_rst_busy", busy_out, 0);
        rst_in = 1'b0;
        glog.delete();
        wait_grants(1, 10, "t4_grant_timeout");
        if (glog.size() >= 1) chk("t4_first_grant", glog[0], 0);

        // Request dropped during its own frame
        do_reset();
        req_in = 4'b0011;
        wait_grants(2, 40, "t5_timeout");
        req_in = 4'b1101;
        wait_grants(3, 40, "t5_timeout2");
        req_in = '0;
        wait_idle(20, "t5_idle");
        tick();
        tick();
        if (glog.size() >= 3) begin
            chk("t5_g0", glog[0], 0);
            chk("t5_g1", glog[1], 1);
            chk("t5_g2", glog[2], 2);
        end
        chk("t5_len", wr_log.size(), 3 * fl);

        // Randomized soak
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            req_in      = N'($urandom);
            PipeFull_in = ($urandom_range(0, 3) == 0);
            rst_in      = ($urandom_range(0, 299) == 0);
            tick();
        end
        rst_in      = 1'b0;
        req_in      = '0;
        PipeFull_in = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
